// File: rtl/bg_frame_sequencer_if.sv
// rtl/bg_frame_sequencer_if.sv - timing-side inputs and frame-buffer controls of the sequencer
interface bg_frame_sequencer_if #(
  parameter int ADDR_W   = 18,
  parameter int PERIOD_W = 8
);
  logic                vtcvde;
  logic                vtc_vsync;
  logic                ref_req;
  logic [PERIOD_W-1:0] ref_period;
  logic [ADDR_W-1:0]   addr_1_b;
  logic                en_ram1;
  logic                en_ram2;
  logic                ref_we;
  logic                acc_en;
  logic                frame_start;
  logic [1:0]          mode;
  logic                frame_err;

  modport master (
    output vtcvde, vtc_vsync, ref_req, ref_period,
    input  addr_1_b, en_ram1, en_ram2, ref_we, acc_en, frame_start, mode, frame_err
  );

  modport slave (
    input  vtcvde, vtc_vsync, ref_req, ref_period,
    output addr_1_b, en_ram1, en_ram2, ref_we, acc_en, frame_start, mode, frame_err
  );
endinterface

// File: rtl/bg_frame_sequencer.sv
// rtl/bg_frame_sequencer.sv - raster tracking, capture/run frame decision and frame-buffer enables
module bg_frame_sequencer #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 360,
  parameter int ADDR_W   = 18,
  parameter int PERIOD_W = 8
) (
  input logic              pclk,
  input logic              reset,
  bg_frame_sequencer_if.slave bus
);
  localparam int FRAME_PIX = H_ACTIVE * V_ACTIVE;
  localparam logic [ADDR_W:0] LAST = FRAME_PIX[ADDR_W:0];

  typedef enum logic [1:0] {IDLE = 2'b00, CAPTURE = 2'b01, RUN = 2'b10} state_t;

  state_t              state;
  state_t              edge_state;
  state_t              pix_state;
  logic                vsync_q;
  logic                req_pend;
  logic [ADDR_W:0]     pix;
  logic [PERIOD_W-1:0] frm_cnt;
  logic [ADDR_W-1:0]   addr_q;
  logic                en_ram1_q, en_ram2_q, ref_we_q, acc_en_q, frame_start_q, frame_err_q;
  logic                vs_rise, period_hit, pix_ok, overrun;

  assign vs_rise    = bus.vtc_vsync & ~vsync_q;
  assign period_hit = (bus.ref_period != '0) && (frm_cnt == bus.ref_period - 1'b1);
  assign edge_state = (state == IDLE || req_pend || bus.ref_req || period_hit) ? CAPTURE : RUN;
  assign pix_state  = vs_rise ? edge_state : state;
  // A pixel on the vsync edge belongs to the new frame, so it is never an overrun.
  assign overrun    = bus.vtcvde && !vs_rise && state != IDLE && pix == LAST;
  assign pix_ok     = bus.vtcvde && (vs_rise || (state != IDLE && pix != LAST));

  always_ff @(posedge pclk) begin
    if (reset) begin
      state         <= IDLE;
      vsync_q       <= 1'b0;
      req_pend      <= 1'b0;
      pix           <= '0;
      frm_cnt       <= '0;
      addr_q        <= '0;
      en_ram1_q     <= 1'b0;
      en_ram2_q     <= 1'b0;
      ref_we_q      <= 1'b0;
      acc_en_q      <= 1'b0;
      frame_start_q <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      vsync_q       <= bus.vtc_vsync;
      frame_start_q <= vs_rise;

      if (pix_ok) begin
        addr_q <= vs_rise ? '0 : pix[ADDR_W-1:0];
        pix    <= vs_rise ? (ADDR_W+1)'(1) : pix + 1'b1;
      end else if (vs_rise) begin
        pix <= '0;
      end

      en_ram1_q <= pix_ok && pix_state == RUN;
      en_ram2_q <= pix_ok;
      ref_we_q  <= pix_ok && pix_state == CAPTURE;
      acc_en_q  <= pix_ok && pix_state == RUN;

      if (vs_rise)
        frame_err_q <= (state != IDLE) && (pix != LAST);
      else if (overrun)
        frame_err_q <= 1'b1;

      if (vs_rise) begin
        state <= edge_state;
        if (edge_state == CAPTURE) begin
          frm_cnt  <= '0;
          req_pend <= 1'b0;
        end else if (frm_cnt != '1) begin
          frm_cnt <= frm_cnt + 1'b1;
        end
      end else if (state != IDLE && bus.ref_req) begin
        req_pend <= 1'b1;
      end
    end
  end

  assign bus.addr_1_b    = addr_q;
  assign bus.en_ram1     = en_ram1_q;
  assign bus.en_ram2     = en_ram2_q;
  assign bus.ref_we      = ref_we_q;
  assign bus.acc_en      = acc_en_q;
  assign bus.frame_start = frame_start_q;
  assign bus.mode        = state;
  assign bus.frame_err   = frame_err_q;
endmodule
